// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX pipeline stage: ALU op codes, result-source
// codes, forwarding select codes and register index width.
package id_ex_stage_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    // x0 is hardwired to zero, so a write to it must never be forwarded.
    function automatic logic fwd_hit(input logic                 reg_write,
                                     input logic [REG_IDX_W-1:0] rd,
                                     input logic [REG_IDX_W-1:0] rs);
        return reg_write && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Operand forwarding select: memory stage wins over writeback when both
// hold the register an execute-stage source needs.
module forward_unit
    import id_ex_stage_pkg::*;
(
    input  logic [REG_IDX_W-1:0] Rs1_E,
    input  logic [REG_IDX_W-1:0] Rs2_E,
    input  logic [REG_IDX_W-1:0] Rd_M,
    input  logic [REG_IDX_W-1:0] Rd_W,
    input  logic                 RegWrite_M,
    input  logic                 RegWrite_W,
    output logic [1:0]           ForwardA,
    output logic [1:0]           ForwardB
);

    always_comb begin
        ForwardA = FWD_NONE;
        if (fwd_hit(RegWrite_M, Rd_M, Rs1_E))
            ForwardA = FWD_MEM;
        else if (fwd_hit(RegWrite_W, Rd_W, Rs1_E))
            ForwardA = FWD_WB;
    end

    always_comb begin
        ForwardB = FWD_NONE;
        if (fwd_hit(RegWrite_M, Rd_M, Rs2_E))
            ForwardB = FWD_MEM;
        else if (fwd_hit(RegWrite_W, Rd_W, Rs2_E))
            ForwardB = FWD_WB;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding muxes and load-use hazard
// detection. Flush inserts a bubble and takes priority over stall.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int width = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 valid_D,
    input  logic [width-1:0]     RD1_D,
    input  logic [width-1:0]     RD2_D,
    input  logic [width-1:0]     ImmExt_D,
    input  logic [REG_IDX_W-1:0] Rs1_D,
    input  logic [REG_IDX_W-1:0] Rs2_D,
    input  logic [REG_IDX_W-1:0] Rd_D,
    input  logic                 AluSrc_D,
    input  logic [2:0]           AluControl_D,
    input  logic                 RegWrite_D,
    input  logic                 MemWrite_D,
    input  logic [1:0]           ResultSrc_D,
    input  logic [width-1:0]     ALUResult_M,
    input  logic [REG_IDX_W-1:0] Rd_M,
    input  logic                 RegWrite_M,
    input  logic [width-1:0]     Result_W,
    input  logic [REG_IDX_W-1:0] Rd_W,
    input  logic                 RegWrite_W,
    output logic [width-1:0]     SrcA_E,
    output logic [width-1:0]     SrcB_E,
    output logic [2:0]           AluControl_E,
    output logic [width-1:0]     WriteData_E,
    output logic [REG_IDX_W-1:0] Rd_E,
    output logic                 RegWrite_E,
    output logic                 MemWrite_E,
    output logic                 valid_E,
    output logic [1:0]           ResultSrc_E,
    output logic                 lwStall
);

    logic [width-1:0]     r_rd1;
    logic [width-1:0]     r_rd2;
    logic [width-1:0]     r_imm;
    logic [REG_IDX_W-1:0] r_rs1;
    logic [REG_IDX_W-1:0] r_rs2;
    logic [REG_IDX_W-1:0] r_rd;
    logic                 r_alu_src;
    logic [2:0]           r_alu_ctrl;
    logic                 r_reg_write;
    logic                 r_mem_write;
    logic [1:0]           r_result_src;
    logic                 r_valid;

    logic [1:0]           w_fwd_a;
    logic [1:0]           w_fwd_b;
    logic [width-1:0]     w_src_a;
    logic [width-1:0]     w_rs2_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_alu_src    <= 1'b0;
            r_alu_ctrl   <= '0;
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_result_src <= '0;
            r_valid      <= 1'b0;
        end else if (flush) begin
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_alu_src    <= 1'b0;
            r_alu_ctrl   <= '0;
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_result_src <= '0;
            r_valid      <= 1'b0;
        end else if (!stall) begin
            r_rd1        <= RD1_D;
            r_rd2        <= RD2_D;
            r_imm        <= ImmExt_D;
            r_rs1        <= Rs1_D;
            r_rs2        <= Rs2_D;
            r_rd         <= Rd_D;
            r_alu_src    <= AluSrc_D;
            r_alu_ctrl   <= AluControl_D;
            r_reg_write  <= RegWrite_D;
            r_mem_write  <= MemWrite_D;
            r_result_src <= ResultSrc_D;
            r_valid      <= valid_D;
        end
    end

    forward_unit u_forward_unit (
        .Rs1_E      (r_rs1),
        .Rs2_E      (r_rs2),
        .Rd_M       (Rd_M),
        .Rd_W       (Rd_W),
        .RegWrite_M (RegWrite_M),
        .RegWrite_W (RegWrite_W),
        .ForwardA   (w_fwd_a),
        .ForwardB   (w_fwd_b)
    );

    // Select code 11 cannot occur; it falls back to the registered operand.
    always_comb begin
        w_src_a = r_rd1;
        case (w_fwd_a)
            FWD_WB:  w_src_a = Result_W;
            FWD_MEM: w_src_a = ALUResult_M;
            default: w_src_a = r_rd1;
        endcase
    end

    always_comb begin
        w_rs2_val = r_rd2;
        case (w_fwd_b)
            FWD_WB:  w_rs2_val = Result_W;
            FWD_MEM: w_rs2_val = ALUResult_M;
            default: w_rs2_val = r_rd2;
        endcase
    end

    assign SrcA_E       = w_src_a;
    assign WriteData_E  = w_rs2_val;
    assign SrcB_E       = r_alu_src ? r_imm : w_rs2_val;
    assign AluControl_E = r_alu_ctrl;
    assign Rd_E         = r_rd;
    assign RegWrite_E   = r_reg_write;
    assign MemWrite_E   = r_mem_write;
    assign valid_E      = r_valid;
    assign ResultSrc_E  = r_result_src;

    // Only reported upstream; the hazard controller does the stall/flush.
    assign lwStall = r_valid && valid_D && (r_result_src == RES_LOAD) &&
                     (r_rd != '0) && ((r_rd == Rs1_D) || (r_rd == Rs2_D));

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: width, default 32, datapath width of operands, immediate and results.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 stall  in  1  hold all stage registers.
REQ-005 flush  in  1  load a bubble; priority over stall.
REQ-006 valid_D  in  1  decode-side instruction valid.
REQ-007 RD1_D, RD2_D, ImmExt_D  in  width each  register-file read data and extended immediate.
REQ-008 Rs1_D, Rs2_D, Rd_D  in  5 each  source and destination register indices.
REQ-009 AluSrc_D  in  1  selects ImmExt for SrcB; AluControl_D  in  3  ALU op code.
REQ-010 RegWrite_D, MemWrite_D  in  1 each; ResultSrc_D  in  2 (00 ALU, 01 load, 10 PC+4).
REQ-011 ALUResult_M  in  width, Rd_M  in  5, RegWrite_M  in  1  memory-stage forward source.
REQ-012 Result_W  in  width, Rd_W  in  5, RegWrite_W  in  1  writeback-stage forward source.
REQ-013 SrcA_E, SrcB_E  out  width  ALU operands; AluControl_E  out  3  ALU op code.
REQ-014 WriteData_E  out  width  forwarded store data.
REQ-015 Rd_E  out  5; RegWrite_E, MemWrite_E, valid_E  out  1 each; ResultSrc_E  out  2.
REQ-016 lwStall  out  1  load-use hazard request to the upstream hazard control.

Function
REQ-017 Registered fields: RD1, RD2, ImmExt, Rs1, Rs2, Rd, AluSrc, AluControl, RegWrite, MemWrite, ResultSrc, valid.
REQ-018 Rising edge, flush=1: valid, RegWrite, MemWrite cleared; all other fields cleared to 0; stall ignored.
REQ-019 Rising edge, flush=0 and stall=1: every registered field holds its value.
REQ-020 Rising edge, flush=0 and stall=0: every field captures its _D input; one-cycle latency D to E.
REQ-021 ForwardA: 10 if RegWrite_M and Rd_M!=0 and Rd_M==Rs1_E; else 01 if RegWrite_W and Rd_W!=0 and Rd_W==Rs1_E; else 00. ForwardB same with Rs2_E.
REQ-022 Memory-stage forward has priority over writeback when both match.
REQ-023 Register x0 never forwarded; reads of x0 use registered RD value.
REQ-024 SrcA_E = RD1_E / Result_W / ALUResult_M for ForwardA 00/01/10; code 11 unreachable, selects RD1_E.
REQ-025 WriteData_E = forwarded RS2 value per ForwardB; SrcB_E = ImmExt_E when AluSrc_E=1, else WriteData_E.
REQ-026 Forwarding and operand muxes are combinational from registered fields and current M/W inputs.
REQ-027 AluControl_E passed unmodified, including codes the ALU does not implement (ALU yields 0).
REQ-028 lwStall = valid_E and valid_D and ResultSrc_E==01 and Rd_E!=0 and (Rd_E==Rs1_D or Rd_E==Rs2_D); combinational.
REQ-029 Block does not act on lwStall itself; upstream asserts stall on IF/ID and flush on this stage.
REQ-030 Outputs while valid_E=0 are don't-care except RegWrite_E, MemWrite_E = 0.

Reset
REQ-031 rst_n low asynchronously clears all registered fields to 0 (valid_E=0, RegWrite_E=0, MemWrite_E=0, ResultSrc_E=00, AluControl_E=000, Rd_E=0).
REQ-032 Reset asserted mid-instruction discards it; no forward or lwStall after reset until a valid capture.
REQ-033 Release of rst_n is synchronised externally; first capture on first rising edge with rst_n high.

Structure
REQ-034 Shared package: ALU op codes (ADD 000, SUB 001, AND 010, OR 011, SLT 101), ResultSrc codes, forward-select codes, register index width 5.
REQ-035 One sub-module, forward_unit: computes ForwardA/ForwardB from Rs1_E, Rs2_E, Rd_M, Rd_W, RegWrite_M, RegWrite_W.

Verification
REQ-036 Capture: RD1_D=5, RD2_D=7, AluSrc_D=0, AluControl_D=000, no hazards -> next cycle SrcA_E=5, SrcB_E=7, valid_E=1.
REQ-037 Forward priority: Rs1_E=3, Rd_M=3, RegWrite_M=1, ALUResult_M=0x10, Rd_W=3, RegWrite_W=1, Result_W=0x20 -> SrcA_E=0x10; drop RegWrite_M -> 0x20.
REQ-038 x0 guard: Rs2_E=0, Rd_M=0, RegWrite_M=1, ALUResult_M=0xFF, RD2_E=0 -> WriteData_E=0, SrcB_E=0.
REQ-039 Load-use: ResultSrc_E=01, Rd_E=4, valid_E=1, Rs2_D=4, valid_D=1 -> lwStall=1; Rd_E=0 -> lwStall=0.
REQ-040 Stall/flush: stall=1 two cycles -> fields hold; stall=1 and flush=1 together -> valid_E=0, RegWrite_E=0 next edge.
REQ-041 Async reset: rst_n low between edges with valid_E=1, RegWrite_E=1 -> both 0 immediately, before next clk edge.
